// File: rtl/ws2812_rx_if.sv
// Decoded-pixel output bundle of the WS2812 receiver; the decoder drives it, consumers observe it.
interface ws2812_rx_if;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [8:0]  pixel_index;
  logic        frame_done;
  logic [8:0]  frame_pixels;
  logic        error;
  logic        busy;

  modport master (
    output pixel, pixel_valid, pixel_index, frame_done, frame_pixels, error, busy
  );

  modport slave (
    input pixel, pixel_valid, pixel_index, frame_done, frame_pixels, error, busy
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812B pulse-width decoder: 24-bit pixel words, frame-end detection and protocol errors.
// Outputs are registered; strobes land 3 clk after the triggering din edge/sample. No backpressure.
module ws2812_rx #(
  parameter int unsigned BIT_THRESH   = 25,
  parameter int unsigned MIN_HIGH     = 4,
  parameter int unsigned MAX_HIGH     = 100,
  parameter int unsigned RESET_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         din,
  ws2812_rx_if.master  rx
);

  localparam logic [11:0] THRESH_L = 12'(BIT_THRESH);
  localparam logic [11:0] MIN_L    = 12'(MIN_HIGH);
  localparam logic [11:0] MAX_L    = 12'(MAX_HIGH);
  localparam logic [11:0] RESET_L  = 12'(RESET_CYCLES);

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t      state, state_n;
  logic        din_m, din_s;
  logic [11:0] run_cnt, run_n, run_inc;
  logic [4:0]  bit_cnt, bit_n;
  logic [8:0]  pix_cnt, pix_n, pix_inc;
  logic [23:0] shreg, shreg_n;
  logic        bit_val;

  logic [23:0] pixel_n;
  logic        pv_n;
  logic [8:0]  idx_n;
  logic        fd_n;
  logic [8:0]  fp_n;
  logic        err_n;
  logic        busy_n;

  assign run_inc = (run_cnt == 12'hFFF) ? run_cnt : run_cnt + 12'd1;
  assign pix_inc = (pix_cnt == 9'd511) ? pix_cnt : pix_cnt + 9'd1;
  assign bit_val = (run_cnt >= THRESH_L);

  always_comb begin
    state_n = state;
    run_n   = run_cnt;
    bit_n   = bit_cnt;
    pix_n   = pix_cnt;
    shreg_n = shreg;
    pixel_n = rx.pixel;
    pv_n    = 1'b0;
    idx_n   = rx.pixel_index;
    fd_n    = 1'b0;
    fp_n    = rx.frame_pixels;
    err_n   = 1'b0;

    case (state)
      SYNC: begin
        if (din_s) begin
          run_n = 12'd0;
        end else if (run_inc >= RESET_L) begin
          state_n = IDLE;
          run_n   = 12'd0;
        end else begin
          run_n = run_inc;
        end
      end

      IDLE: begin
        if (din_s) begin
          state_n = HIGH;
          run_n   = 12'd1;
        end
      end

      HIGH: begin
        if (din_s) begin
          run_n = run_inc;
          // Stuck line: abandon the frame and wait for a clean reset gap.
          if (run_inc > MAX_L) begin
            err_n   = 1'b1;
            state_n = SYNC;
            run_n   = 12'd0;
            bit_n   = 5'd0;
            pix_n   = 9'd0;
          end
        end else if (run_cnt < MIN_L) begin
          err_n   = 1'b1;
          state_n = SYNC;
          run_n   = 12'd0;
          bit_n   = 5'd0;
          pix_n   = 9'd0;
        end else begin
          shreg_n = {bit_val, shreg[23:1]};
          state_n = LOW;
          run_n   = 12'd1;
          if (bit_cnt == 5'd23) begin
            pixel_n = shreg_n;
            pv_n    = 1'b1;
            idx_n   = pix_cnt;
            pix_n   = pix_inc;
            bit_n   = 5'd0;
          end else begin
            bit_n = bit_cnt + 5'd1;
          end
        end
      end

      LOW: begin
        if (din_s) begin
          state_n = HIGH;
          run_n   = 12'd1;
        end else if (run_inc >= RESET_L) begin
          // Frame end; a dangling partial word is reported and dropped.
          fd_n    = 1'b1;
          fp_n    = pix_cnt;
          err_n   = (bit_cnt != 5'd0);
          pix_n   = 9'd0;
          bit_n   = 5'd0;
          state_n = IDLE;
          run_n   = 12'd0;
        end else begin
          run_n = run_inc;
        end
      end

      default: begin
        state_n = SYNC;
        run_n   = 12'd0;
      end
    endcase

    busy_n = (state_n == HIGH) || (state_n == LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      din_m           <= 1'b0;
      din_s           <= 1'b0;
      state           <= SYNC;
      run_cnt         <= 12'd0;
      bit_cnt         <= 5'd0;
      pix_cnt         <= 9'd0;
      shreg           <= 24'd0;
      rx.pixel        <= 24'd0;
      rx.pixel_valid  <= 1'b0;
      rx.pixel_index  <= 9'd0;
      rx.frame_done   <= 1'b0;
      rx.frame_pixels <= 9'd0;
      rx.error        <= 1'b0;
      rx.busy         <= 1'b0;
    end else begin
      din_m           <= din;
      din_s           <= din_m;
      state           <= state_n;
      run_cnt         <= run_n;
      bit_cnt         <= bit_n;
      pix_cnt         <= pix_n;
      shreg           <= shreg_n;
      rx.pixel        <= pixel_n;
      rx.pixel_valid  <= pv_n;
      rx.pixel_index  <= idx_n;
      rx.frame_done   <= fd_n;
      rx.frame_pixels <= fp_n;
      rx.error        <= err_n;
      rx.busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus queues expected strobes, a monitor pops and compares them.
module tb_ws2812_rx;

  localparam int K_PIX       = 0;
  localparam int K_FRAME     = 1;
  localparam int K_ERR       = 2;
  localparam int K_FRAME_ERR = 3;

  typedef struct {
    int          kind;
    logic [23:0] data;
    logic [8:0]  idx;
  } exp_t;

  logic clk;
  logic reset;
  logic din;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  ws2812_rx_if rx ();

  ws2812_rx #(
    .BIT_THRESH   (25),
    .MIN_HIGH     (4),
    .MAX_HIGH     (100),
    .RESET_CYCLES (1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .rx    (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int kind, input logic [23:0] data, input logic [8:0] idx);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  // Transmitter timing: T0H 17 / T0L 35, T1H 33 / T1L 19.
  task automatic send_bits_tx(input logic [23:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (w[i]) send_bit(33, 19);
      else      send_bit(17, 35);
    end
  endtask

  task automatic send_word_fast(input logic [23:0] w);
    for (int i = 0; i < 24; i++) begin
      if (w[i]) send_bit(30, 5);
      else      send_bit(10, 5);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_pixel"},        32'(rx.pixel),        32'd0);
    check_eq({tag, "_pixel_valid"},  32'(rx.pixel_valid),  32'd0);
    check_eq({tag, "_pixel_index"},  32'(rx.pixel_index),  32'd0);
    check_eq({tag, "_frame_done"},   32'(rx.frame_done),   32'd0);
    check_eq({tag, "_frame_pixels"}, 32'(rx.frame_pixels), 32'd0);
    check_eq({tag, "_error"},        32'(rx.error),        32'd0);
    check_eq({tag, "_busy"},         32'(rx.busy),         32'd0);
  endtask

  // Monitor: every strobe cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (rx.pixel_valid || rx.frame_done || rx.error)) begin
      int   kind;
      exp_t e;
      if (rx.pixel_valid && !rx.frame_done && !rx.error)      kind = K_PIX;
      else if (!rx.pixel_valid && rx.frame_done && rx.error)  kind = K_FRAME_ERR;
      else if (!rx.pixel_valid && rx.frame_done)              kind = K_FRAME;
      else if (!rx.pixel_valid && rx.error)                   kind = K_ERR;
      else                                                    kind = 4;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: kind=%0d pixel=%06h idx=%0d frame_pixels=%0d, expected no event",
                 kind, rx.pixel, rx.pixel_index, rx.frame_pixels);
      end else begin
        e = exp_q.pop_front();
        if (kind != e.kind) begin
          errors++;
          $display("FAIL event_kind: got kind=%0d, expected kind=%0d (data=%06h idx=%0d)",
                   kind, e.kind, e.data, e.idx);
        end else if (kind == K_PIX && (rx.pixel !== e.data || rx.pixel_index !== e.idx)) begin
          errors++;
          $display("FAIL pixel: got %06h idx %0d, expected %06h idx %0d",
                   rx.pixel, rx.pixel_index, e.data, e.idx);
        end else if ((kind == K_FRAME || kind == K_FRAME_ERR) && rx.frame_pixels !== e.idx) begin
          errors++;
          $display("FAIL frame_pixels: got %0d, expected %0d", rx.frame_pixels, e.idx);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    din    = 1'b0;
    reset  = 1'b1;
    repeat (4) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");

    // Initial sync gap, then one word at transmitter timing.
    drive(1'b0, 1000);
    push(K_PIX, 24'h00B000, 9'd0);
    send_bits_tx(24'h00B000, 24);
    push(K_FRAME, 24'd0, 9'd1);
    drive(1'b0, 2001);
    @(negedge clk);
    check_eq("busy_after_frame", 32'(rx.busy), 32'd0);

    // 65 back-to-back words with short low gaps.
    for (int i = 0; i < 65; i++) begin
      logic [23:0] w;
      w = (i % 2 == 0) ? 24'h00F060 : 24'hB05000;
      push(K_PIX, w, 9'(i));
      send_word_fast(w);
    end
    push(K_FRAME, 24'd0, 9'd65);
    drive(1'b0, 1050);

    // Boundaries in one word: 24 -> 0, 25 -> 1, 4 -> 0, 100 -> 1.
    push(K_PIX, 24'h00000A, 9'd0);
    send_bit(24, 35);
    send_bit(25, 19);
    send_bit(4, 35);
    send_bit(100, 19);
    send_bits_tx(24'h000000, 20);
    push(K_FRAME, 24'd0, 9'd1);
    drive(1'b0, 1050);

    push(K_ERR, 24'd0, 9'd0);
    send_bit(3, 1100);
    push(K_ERR, 24'd0, 9'd0);
    send_bit(101, 1100);

    // Partial word ends the frame with an error in the same cycle.
    send_bits_tx(24'h000ABC, 12);
    @(negedge clk);
    check_eq("busy_mid_word", 32'(rx.busy), 32'd1);
    push(K_FRAME_ERR, 24'd0, 9'd0);
    drive(1'b0, 1000);
    drive(1'b0, 50);

    // Stuck high mid-word, exactly one reset gap, then a good word.
    send_bits_tx(24'h000015, 5);
    push(K_ERR, 24'd0, 9'd0);
    drive(1'b1, 500);
    drive(1'b0, 1000);
    push(K_PIX, 24'h5A3C81, 9'd0);
    send_bits_tx(24'h5A3C81, 24);
    push(K_FRAME, 24'd0, 9'd1);
    drive(1'b0, 1050);

    // Reset after bit 10 clears everything silently.
    send_bits_tx(24'h3FF00F, 10);
    @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    drive(1'b0, 1000);
    push(K_PIX, 24'hC30F96, 9'd0);
    send_bits_tx(24'hC30F96, 24);
    push(K_FRAME, 24'd0, 9'd1);
    drive(1'b0, 1050);

    repeat (20) @(posedge clk);
    check_eq("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Single-wire WS2812B-format decoder: recovers 24-bit pixel words from an NRZ pulse-width datastream and reports pixel and frame boundaries. It is the receive end of the LED-matrix drive path. It is used in loopback to check the matrix transmitter in hardware and in simulation, and to snoop the matrix data line. Clock is 40 MHz, the same as the transmitter, so all thresholds are in clk cycles.

## Interface
- BIT_THRESH, 25: high-pulse length (cycles) at or above which a bit decodes as 1.
- MIN_HIGH, 4: high pulses shorter than this are glitches (error).
- MAX_HIGH, 100: high pulses longer than this are stuck-line errors.
- RESET_CYCLES, 1000: continuous low cycles that end a frame; legal range 200..4095.
- clk  in  1  40 MHz system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- din  in  1  asynchronous serial data line.
- pixel  out  24  last decoded word; first received bit in pixel[0].
- pixel_valid  out  1  one-cycle strobe, pixel/pixel_index valid.
- pixel_index  out  9  0-based pixel position in current frame.
- frame_done  out  1  one-cycle strobe at frame end.
- frame_pixels  out  9  complete pixels in the frame just ended; valid with frame_done.
- error  out  1  one-cycle strobe on any protocol violation.
- busy  out  1  high while a frame is in progress (state HIGH or LOW).

## Operation
- din passes a 2-flop synchronizer, giving din_s. All decoding uses din_s.
- Counters:
  - run_cnt, 12-bit, saturating: cycles din_s has held its current level.
  - bit_cnt, 5-bit: bits received in the current word.
  - pix_cnt, 9-bit: pixels in the current frame; saturates at 511. Pixels beyond 511 are still delivered with index 511.
- Shift register: right shift with the new bit entering at bit 23. After 24 bits, bit 0 holds the first bit received.
- States:
  - SYNC: entered on reset and after an error. Counts low cycles; any din_s high clears the count. When the count reaches RESET_CYCLES, go to IDLE. No frame_done is issued.
  - IDLE: din_s rising goes to HIGH with run_cnt=1.
  - HIGH: on din_s falling, check the length L = run_cnt.
    - L<MIN_HIGH: error, go to SYNC.
    - Otherwise the bit is (L>=BIT_THRESH). Shift it in and go to LOW.
    - If run_cnt exceeds MAX_HIGH while still high: error, discard the partial word, go to SYNC.
  - LOW: din_s rising goes to HIGH.
    - When run_cnt reaches RESET_CYCLES: frame_done, frame_pixels=pix_cnt, clear pix_cnt, go to IDLE.
    - If bit_cnt≠0 at that point (partial word), also pulse error; the partial word is dropped.
- At the 24th bit: pixel loads the shift register, pixel_valid pulses, pixel_index=pix_cnt, pix_cnt increments, bit_cnt clears.
- Low-gap length between bits is not checked, apart from the RESET_CYCLES frame end.
- Reset values:
  - pixel=0, pixel_valid=0, pixel_index=0, frame_done=0, frame_pixels=0, error=0, busy=0.
  - State SYNC; all counters 0.
- Reset mid-frame: the partial word and pixel count are discarded with no strobes. The block must then see RESET_CYCLES low before decoding again.

## Timing
- All outputs are registered.
- pixel_valid asserts 3 clk after the din falling edge that ends bit 24: 2 synchronizer cycles plus 1 output register.
- frame_done asserts 3 clk after din_s has been low RESET_CYCLES cycles, i.e. RESET_CYCLES+3 cycles after the din falling edge.
- error asserts 3 clk after the din edge or sample that triggers it.
- Strobes are exactly one cycle wide.
- pixel and pixel_index hold their values until the next pixel_valid. frame_pixels holds until the next frame_done.
- pixel_valid and frame_done are never high in the same cycle.
- error and frame_done may be high in the same cycle only in the partial-word case.
- With transmitter timing (T0H 17, T1H 33, T0L 35, T1L 19 cycles): one word takes 1248 cycles.
- Throughput: one bit per high+low pair of at least MIN_HIGH+1 cycles.

## Test plan
- Word decode: 1000 low cycles, then 24'h00B000 sent LSB-first at transmitter timing, then 2001 low cycles. Required: one pixel_valid with pixel=24'h00B000 and pixel_index=0; then frame_done with frame_pixels=1, error never asserted.
- Full face: 65 back-to-back words, alternating 24'h00F060 and 24'hB05000. Required: 65 pixel_valid strobes with indices 0..64 and correct values; frame_done with frame_pixels=65.
- Threshold boundaries:
  - High 24 cycles decodes 0; high 25 decodes 1.
  - High 3 cycles gives error; high 4 is accepted.
  - High 100 is accepted; high 101 gives error.
  - Check each case via the resulting pixel value or error strobe.
- Stuck high: din held high for 500 cycles mid-word. Required: single error, no pixel_valid. The next word is decoded only after 1000 low cycles.
- Partial word: 12 bits, then 1000 low cycles. Required: frame_done with frame_pixels=0 and error in the same cycle; no pixel_valid.
- Reset mid-word: reset asserted for 1 cycle after bit 10. Required: all outputs return to 0, no strobes. A following word preceded by 1000 low cycles decodes correctly with index 0.
